// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART with a first-word-fall-through RX FIFO.
//
// Transmit side takes bytes through a valid/ready handshake and serialises them
// on TXD. Receive side synchronises RXD, deserialises frames and pushes good
// bytes into the FIFO. Overrun, framing and parity errors are sticky until
// Err_Clr.
//
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   TX_Valid/TX_DataIn/TX_Ready  transmit byte handshake
//   TXD                       serial out (idle high)
//   RXD                       serial in (asynchronous)
//   Data_Out/Data_Read        FIFO head and pop strobe
//   Full/Empty/Count          FIFO status
//   Overrun/Frame_Err/Parity_Err  sticky error flags, Err_Clr clears them
//
// Optional feature macro: UART_PARITY_EN adds a parity bit to every frame
// (PARITY_ODD selects odd/even). Without it Parity_Err is tied low.
module uart_cfg #(
    parameter int FREQ_CLK   = 100000000,
    parameter int TX_SPEED   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              TX_Valid,
    input  logic [DATA_BITS-1:0]              TX_DataIn,
    output logic                              TX_Ready,
    output logic                              TXD,
    input  logic                              RXD,
    output logic [DATA_BITS-1:0]              Data_Out,
    input  logic                              Data_Read,
    output logic                              Full,
    output logic                              Empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   Count,
    output logic                              Overrun,
    output logic                              Frame_Err,
    output logic                              Parity_Err,
    input  logic                              Err_Clr
);
    localparam int BIT_CYCLES = FREQ_CLK / TX_SPEED;
    localparam int CW   = $clog2(STOP_BITS * BIT_CYCLES + 1);
    localparam int IW   = $clog2(DATA_BITS);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0]   STOP_LAST = CW'(STOP_BITS * BIT_CYCLES - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_WAIT   = 3'd5
    } state_e;

    // Parity bit value that makes the frame's ones count even (or odd).
    function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // ---------------- transmitter ----------------
    state_e                tx_state_q;
    logic [CW-1:0]         tx_cnt_q;
    logic [IW-1:0]         tx_idx_q;
    logic [DATA_BITS-1:0]  tx_sh_q;
    logic                  txd_q;
    logic                  tx_ready_q;
`ifdef UART_PARITY_EN
    logic                  tx_par_q;
`endif

    // TX FSM: each bit is held for BIT_CYCLES cycles, txd_q is the pin register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= {CW{1'b0}};
            tx_idx_q   <= {IW{1'b0}};
            tx_sh_q    <= {DATA_BITS{1'b0}};
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    if (TX_Valid && tx_ready_q) begin
                        tx_sh_q    <= TX_DataIn;
`ifdef UART_PARITY_EN
                        tx_par_q   <= parity_f(TX_DataIn);
`endif
                        txd_q      <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_cnt_q   <= {CW{1'b0}};
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= {CW{1'b0}};
                        tx_idx_q   <= {IW{1'b0}};
                        txd_q      <= tx_sh_q[0];
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= {CW{1'b0}};
                        if (tx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            txd_q      <= tx_par_q;
                            tx_state_q <= S_PARITY;
`else
                            txd_q      <= 1'b1;
                            tx_state_q <= S_STOP;
`endif
                        end else begin
                            // Shift register holds the not-yet-sent bits at the bottom.
                            tx_idx_q <= tx_idx_q + 1'b1;
                            tx_sh_q  <= {1'b0, tx_sh_q[DATA_BITS-1:1]};
                            txd_q    <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= {CW{1'b0}};
                        txd_q      <= 1'b1;
                        tx_state_q <= S_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_cnt_q == STOP_LAST) begin
                        tx_cnt_q   <= {CW{1'b0}};
                        tx_ready_q <= 1'b1;
                        tx_state_q <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    txd_q      <= 1'b1;
                    tx_ready_q <= 1'b1;
                    tx_state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TXD      = txd_q;
    assign TX_Ready = tx_ready_q;

    // ---------------- receiver ----------------
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    state_e                rx_state_q;
    logic [CW-1:0]         rx_cnt_q;
    logic [IW-1:0]         rx_idx_q;
    logic [DATA_BITS-1:0]  rx_sh_q;
`ifdef UART_PARITY_EN
    logic                  rx_perr_q;
`endif
    logic                  rx_tick_s, push_s, frame_ev_s, par_ev_s;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RXD;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_tick_s  = (rx_cnt_q == BIT_LAST);
    assign frame_ev_s = (rx_state_q == S_STOP) && rx_tick_s && !rx_sync_q;
`ifdef UART_PARITY_EN
    assign push_s   = (rx_state_q == S_STOP) && rx_tick_s && rx_sync_q && !rx_perr_q;
    assign par_ev_s = (rx_state_q == S_PARITY) && rx_tick_s && (rx_sync_q != parity_f(rx_sh_q));
`else
    assign push_s   = (rx_state_q == S_STOP) && rx_tick_s && rx_sync_q;
    assign par_ev_s = 1'b0;
`endif

    // RX FSM: start bit checked at half a bit, later bits one bit period apart.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= {CW{1'b0}};
            rx_idx_q   <= {IW{1'b0}};
            rx_sh_q    <= {DATA_BITS{1'b0}};
`ifdef UART_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_cnt_q   <= {CW{1'b0}};
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= {CW{1'b0}};
                        rx_idx_q   <= {IW{1'b0}};
                        // Line back high at mid start bit: treat as a glitch.
                        rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_tick_s) begin
                        rx_cnt_q <= {CW{1'b0}};
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
                        if (rx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= S_PARITY;
`else
                            rx_state_q <= S_STOP;
`endif
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_tick_s) begin
                        rx_cnt_q   <= {CW{1'b0}};
                        rx_perr_q  <= (rx_sync_q != parity_f(rx_sh_q));
                        rx_state_q <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (rx_tick_s) begin
                        rx_cnt_q   <= {CW{1'b0}};
                        rx_state_q <= rx_sync_q ? S_IDLE : S_WAIT;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rx_sync_q) begin
                        rx_state_q <= S_IDLE;
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d;
    logic                 pop_s, full_s, wr_en_s, ovr_ev_s;

    assign full_s   = (count_q == DEPTH_C);
    assign pop_s    = Data_Read && (count_q != {CNTW{1'b0}});
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en_s  = push_s && (!full_s || pop_s);
    assign ovr_ev_s = push_s && full_s && !pop_s;

    // FIFO next-state: pointers wrap naturally because depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointer registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CNTW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= rx_sh_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign Data_Out = mem_q[rd_ptr_q];
    assign Full     = full_s;
    assign Empty    = (count_q == {CNTW{1'b0}});
    assign Count    = count_q;

    // ---------------- sticky error flags ----------------
    logic ovr_q, fe_q, pe_q;

    // Sticky flags: a new event wins over a simultaneous clear.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
            pe_q  <= 1'b0;
        end else begin
            ovr_q <= ovr_ev_s   | (ovr_q & ~Err_Clr);
            fe_q  <= frame_ev_s | (fe_q  & ~Err_Clr);
            pe_q  <= par_ev_s   | (pe_q  & ~Err_Clr);
        end
    end

    assign Overrun    = ovr_q;
    assign Frame_Err  = fe_q;
    assign Parity_Err = pe_q;
endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg (default build, no parity).
// Bit period is shortened to 16 clocks through FREQ_CLK/TX_SPEED so that the
// random RX/TX traffic stays short; all other parameters are defaults.
module tb_uart_cfg;
    localparam int BC    = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int NBITS = 1 + DB + 1;

    logic          Clk = 1'b0;
    logic          Rst, TX_Valid, RXD, Data_Read, Err_Clr;
    logic [DB-1:0] TX_DataIn;
    logic          TX_Ready, TXD, Full, Empty, Overrun, Frame_Err, Parity_Err;
    logic [DB-1:0] Data_Out;
    logic [2:0]    Count;

    uart_cfg #(
        .FREQ_CLK(160), .TX_SPEED(10), .DATA_BITS(DB), .STOP_BITS(1),
        .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
    ) dut (
        .Clk(Clk), .Rst(Rst), .TX_Valid(TX_Valid), .TX_DataIn(TX_DataIn),
        .TX_Ready(TX_Ready), .TXD(TXD), .RXD(RXD), .Data_Out(Data_Out),
        .Data_Read(Data_Read), .Full(Full), .Empty(Empty), .Count(Count),
        .Overrun(Overrun), .Frame_Err(Frame_Err), .Parity_Err(Parity_Err),
        .Err_Clr(Err_Clr)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of bytes the receiver should hold, plus flags.
    logic [DB-1:0] model_q[$];
    bit exp_ovr = 1'b0;
    bit exp_fe  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; leaves time 1 unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, ".count"}, 32'(Count), 32'(model_q.size()));
        check_eq({tag, ".empty"}, 32'(Empty), 32'(model_q.size() == 0));
        check_eq({tag, ".full"},  32'(Full),  32'(model_q.size() == DEPTH));
        if (model_q.size() > 0) begin
            check_eq({tag, ".head"}, 32'(Data_Out), 32'(model_q[0]));
        end
        check_eq({tag, ".ovr"},  32'(Overrun),    32'(exp_ovr));
        check_eq({tag, ".fe"},   32'(Frame_Err),  32'(exp_fe));
        check_eq({tag, ".pe"},   32'(Parity_Err), 32'd0);
    endtask

    // Drive one serial frame on RXD, then idle, then update the model.
    task automatic send_rx(input logic [DB-1:0] b, input bit bad_stop);
        RXD = 1'b0;
        step(BC);
        for (int i = 0; i < DB; i++) begin
            RXD = b[i];
            step(BC);
        end
        RXD = !bad_stop;
        step(BC);
        RXD = 1'b1;
        step(2 * BC);
        if (bad_stop) begin
            exp_fe = 1'b1;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic pop_one();
        Data_Read = 1'b1;
        step(1);
        Data_Read = 1'b0;
        if (model_q.size() > 0) begin
            void'(model_q.pop_front());
        end
    endtask

    task automatic clear_errs();
        Err_Clr = 1'b1;
        step(1);
        Err_Clr = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
    endtask

    // Send one byte and check every cycle of the serial frame.
    task automatic send_tx(input logic [DB-1:0] b);
        logic [NBITS-1:0] frame;
        frame = {1'b1, b, 1'b0};   // bit 0 = start, then LSB first, then stop
        check_eq("tx.ready_pre", 32'(TX_Ready), 32'd1);
        TX_Valid  = 1'b1;
        TX_DataIn = b;
        step(1);
        TX_DataIn = DB'($urandom);   // must be ignored while busy
        for (int c = 0; c < NBITS * BC; c++) begin
            check_eq("tx.txd", 32'(TXD), 32'(frame[c / BC]));
            check_eq("tx.busy", 32'(TX_Ready), 32'd0);
            if (c == 3) begin
                TX_Valid = 1'b0;
            end
            step(1);
        end
        check_eq("tx.ready_post", 32'(TX_Ready), 32'd1);
        check_eq("tx.idle", 32'(TXD), 32'd1);
    endtask

    initial begin
        Rst = 1'b1; TX_Valid = 1'b0; TX_DataIn = '0; RXD = 1'b1;
        Data_Read = 1'b0; Err_Clr = 1'b0;
        step(3);
        check_eq("rst.txd",   32'(TXD),        32'd1);
        check_eq("rst.ready", 32'(TX_Ready),   32'd1);
        check_eq("rst.empty", 32'(Empty),      32'd1);
        check_eq("rst.full",  32'(Full),       32'd0);
        check_eq("rst.count", 32'(Count),      32'd0);
        check_eq("rst.dout",  32'(Data_Out),   32'd0);
        check_eq("rst.ovr",   32'(Overrun),    32'd0);
        check_eq("rst.fe",    32'(Frame_Err),  32'd0);
        check_eq("rst.pe",    32'(Parity_Err), 32'd0);
        Rst = 1'b0;
        step(2);

        // Transmit: directed byte then random bytes.
        send_tx(8'hA5);
        for (int i = 0; i < 3; i++) begin
            send_tx(DB'($urandom));
        end

        // Receive a single byte and pop it.
        send_rx(8'h3C, 1'b0);
        check_rx("rx3c");
        pop_one();
        check_rx("rx3c_pop");
        pop_one();   // read while empty is ignored
        check_rx("pop_empty");

        // Random mix of frames, bad frames, pops and clears.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: send_rx(DB'($urandom), 1'b0);
                3:       send_rx(DB'($urandom), 1'b1);
                4:       pop_one();
                default: clear_errs();
            endcase
            check_rx("rand");
        end

        // Overrun: drain, then five frames with no reads.
        while (model_q.size() > 0) pop_one();
        clear_errs();
        for (int i = 1; i <= 5; i++) begin
            send_rx(DB'(i), 1'b0);
            check_rx("ovr_fill");
        end
        for (int i = 0; i < 4; i++) begin
            check_eq("ovr_pop", 32'(Data_Out), 32'(i + 1));
            pop_one();
            check_rx("ovr_drain");
        end
        clear_errs();
        check_rx("ovr_clr");

        // Framing error then a good frame.
        send_rx(8'h55, 1'b1);
        check_rx("fe");
        send_rx(8'h66, 1'b0);
        check_rx("fe_next");
        pop_one();
        clear_errs();

        // Short low glitch: nothing pushed.
        RXD = 1'b0;
        step(4);
        RXD = 1'b1;
        step(3 * BC);
        check_rx("glitch");
        send_rx(8'h9A, 1'b0);
        check_rx("post_glitch");

        // Reset in the middle of a transmitted frame.
        TX_Valid  = 1'b1;
        TX_DataIn = 8'h00;
        step(1);
        TX_Valid  = 1'b0;
        step(3 * BC + 5);
        check_eq("mid.txd_busy", 32'(TX_Ready), 32'd0);
        Rst = 1'b1;
        step(1);
        Rst = 1'b0;
        check_eq("mid.txd",   32'(TXD),      32'd1);
        check_eq("mid.ready", 32'(TX_Ready), 32'd1);
        model_q.delete();
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        check_rx("mid.rx");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
